// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data-memory request/acknowledge port used by the memory stage
interface mem_stage_if #(
    parameter int DATA_WIDTH = 16
) ();
    logic                  req;
    logic                  we;
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  ack;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: LDW/STW over a req/ack port, N/Z/P branch resolution, writeback
module mem_stage #(
    parameter int DATA_WIDTH   = 16,
    parameter int OPCODE_WIDTH = 8,
    parameter int MEM_TIMEOUT  = 8
) (
    input  logic                    I_CLOCK,
    input  logic                    I_RESET_N,
    input  logic                    I_LOCK,
    input  logic [DATA_WIDTH-1:0]   I_ALUOut,
    input  logic [OPCODE_WIDTH-1:0] I_Opcode,
    input  logic [3:0]              I_DestRegIdx,
    input  logic [DATA_WIDTH-1:0]   I_DestValue,
    input  logic                    I_FetchStall,
    input  logic                    I_DepStall,
    mem_stage_if.master             dmem,
    output logic                    O_MemStall,
    output logic                    O_MemErr,
    output logic                    O_LOCK,
    output logic                    O_FetchStall,
    output logic                    O_DepStall,
    output logic [OPCODE_WIDTH-1:0] O_Opcode,
    output logic [3:0]              O_DestRegIdx,
    output logic [DATA_WIDTH-1:0]   O_WBValue,
    output logic                    O_RegWrite,
    output logic                    O_BranchTaken,
    output logic [DATA_WIDTH-1:0]   O_BranchPC
);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD   = 'h00;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = 'h01;
    localparam logic [OPCODE_WIDTH-1:0] OP_AND   = 'h02;
    localparam logic [OPCODE_WIDTH-1:0] OP_ANDI  = 'h03;
    localparam logic [OPCODE_WIDTH-1:0] OP_MOV   = 'h04;
    localparam logic [OPCODE_WIDTH-1:0] OP_MOVI  = 'h05;
    localparam logic [OPCODE_WIDTH-1:0] OP_LDW   = 'h06;
    localparam logic [OPCODE_WIDTH-1:0] OP_STW   = 'h07;
    localparam logic [OPCODE_WIDTH-1:0] OP_BRN   = 'h08;
    localparam logic [OPCODE_WIDTH-1:0] OP_BRZ   = 'h09;
    localparam logic [OPCODE_WIDTH-1:0] OP_BRP   = 'h0A;
    localparam logic [OPCODE_WIDTH-1:0] OP_BRNZ  = 'h0B;
    localparam logic [OPCODE_WIDTH-1:0] OP_BRZP  = 'h0C;
    localparam logic [OPCODE_WIDTH-1:0] OP_BRNP  = 'h0D;
    localparam logic [OPCODE_WIDTH-1:0] OP_BRNZP = 'h0E;
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP   = 'h0F;
    localparam logic [OPCODE_WIDTH-1:0] OP_JSR   = 'h10;
    localparam logic [OPCODE_WIDTH-1:0] OP_JSRR  = 'h11;

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_RD = 2'd1,
        WAIT_WR = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [2:0]              cc_q, cc_d;
    logic                    req_q, req_d;
    logic                    we_q, we_d;
    logic [DATA_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    err_q, err_d;
    logic                    lock_q, lock_d;
    logic                    fstall_q, fstall_d;
    logic                    dstall_q, dstall_d;
    logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d;
    logic [3:0]              dest_q, dest_d;
    logic [DATA_WIDTH-1:0]   wb_q, wb_d;
    logic                    regwr_q, regwr_d;
    logic                    br_q, br_d;
    logic [DATA_WIDTH-1:0]   bpc_q, bpc_d;
    logic [2:0]              br_mask;
    logic                    in_valid;

    // CC ordering is {N, Z, P}
    function automatic logic [2:0] cc_of(input logic [DATA_WIDTH-1:0] v);
        logic zero;
        zero = (v == '0);
        return {v[DATA_WIDTH-1], zero, ~v[DATA_WIDTH-1] & ~zero};
    endfunction

    assign in_valid = I_LOCK & ~I_FetchStall & ~I_DepStall;

    always_comb begin
        br_mask = 3'b000;
        case (I_Opcode)
            OP_BRN:   br_mask = 3'b100;
            OP_BRZ:   br_mask = 3'b010;
            OP_BRP:   br_mask = 3'b001;
            OP_BRNZ:  br_mask = 3'b110;
            OP_BRZP:  br_mask = 3'b011;
            OP_BRNP:  br_mask = 3'b101;
            OP_BRNZP: br_mask = 3'b111;
            default:  br_mask = 3'b000;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cc_d     = cc_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        lock_d   = lock_q;
        fstall_d = fstall_q;
        dstall_d = dstall_q;
        opcode_d = opcode_q;
        dest_d   = dest_q;
        wb_d     = wb_q;
        regwr_d  = 1'b0;
        br_d     = 1'b0;
        bpc_d    = bpc_q;

        case (state_q)
            IDLE: begin
                lock_d   = I_LOCK;
                fstall_d = I_FetchStall;
                dstall_d = I_DepStall;
                opcode_d = I_Opcode;
                dest_d   = I_DestRegIdx;
                if (in_valid) begin
                    case (I_Opcode)
                        OP_ADD, OP_ADDI, OP_AND, OP_ANDI, OP_MOV, OP_MOVI: begin
                            wb_d    = I_ALUOut;
                            regwr_d = 1'b1;
                            cc_d    = cc_of(I_ALUOut);
                        end
                        OP_LDW: begin
                            req_d   = 1'b1;
                            we_d    = 1'b0;
                            addr_d  = I_ALUOut;
                            cnt_d   = '0;
                            state_d = WAIT_RD;
                        end
                        OP_STW: begin
                            req_d   = 1'b1;
                            we_d    = 1'b1;
                            addr_d  = I_ALUOut;
                            wdata_d = I_DestValue;
                            cnt_d   = '0;
                            state_d = WAIT_WR;
                        end
                        OP_BRN, OP_BRZ, OP_BRP, OP_BRNZ, OP_BRZP, OP_BRNP, OP_BRNZP: begin
                            if ((br_mask & cc_q) != 3'b000) begin
                                br_d  = 1'b1;
                                bpc_d = I_ALUOut;
                            end
                        end
                        OP_JMP, OP_JSR, OP_JSRR: begin
                            br_d  = 1'b1;
                            bpc_d = I_ALUOut;
                        end
                        default: ;
                    endcase
                end
            end
            WAIT_RD, WAIT_WR: begin
                // An ack on the limit edge completes normally rather than aborting
                if (dmem.ack) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                    if (state_q == WAIT_RD) begin
                        wb_d    = dmem.rdata;
                        regwr_d = 1'b1;
                        cc_d    = cc_of(dmem.rdata);
                    end
                end else if (cnt_q == CNT_LIMIT) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cc_q     <= 3'b010;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            lock_q   <= 1'b0;
            fstall_q <= 1'b0;
            dstall_q <= 1'b0;
            opcode_q <= '0;
            dest_q   <= '0;
            wb_q     <= '0;
            regwr_q  <= 1'b0;
            br_q     <= 1'b0;
            bpc_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cc_q     <= cc_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            lock_q   <= lock_d;
            fstall_q <= fstall_d;
            dstall_q <= dstall_d;
            opcode_q <= opcode_d;
            dest_q   <= dest_d;
            wb_q     <= wb_d;
            regwr_q  <= regwr_d;
            br_q     <= br_d;
            bpc_q    <= bpc_d;
        end
    end

    // Stall and request share one flop: they rise and fall on the same edges
    assign dmem.req      = req_q;
    assign dmem.we       = we_q;
    assign dmem.addr     = addr_q;
    assign dmem.wdata    = wdata_q;
    assign O_MemStall    = req_q;
    assign O_MemErr      = err_q;
    assign O_LOCK        = lock_q;
    assign O_FetchStall  = fstall_q;
    assign O_DepStall    = dstall_q;
    assign O_Opcode      = opcode_q;
    assign O_DestRegIdx  = dest_q;
    assign O_WBValue     = wb_q;
    assign O_RegWrite    = regwr_q;
    assign O_BranchTaken = br_q;
    assign O_BranchPC    = bpc_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - table-driven and sequence bench for mem_stage
module tb_mem_stage;
    localparam logic [7:0] OP_ADD = 8'h00, OP_ADDI = 8'h01, OP_AND = 8'h02, OP_MOV = 8'h04,
                           OP_MOVI = 8'h05, OP_LDW = 8'h06, OP_STW = 8'h07, OP_BRN = 8'h08,
                           OP_BRZ = 8'h09, OP_BRP = 8'h0A, OP_BRNZ = 8'h0B, OP_BRZP = 8'h0C,
                           OP_BRNP = 8'h0D, OP_BRNZP = 8'h0E, OP_JMP = 8'h0F, OP_JSRR = 8'h11,
                           OP_NOP = 8'hFF;

    logic        clk;
    logic        rst_n;
    logic        lock_i, fs_i, ds_i;
    logic [15:0] alu_i, dval_i;
    logic [7:0]  op_i;
    logic [3:0]  dest_i;
    logic        mem_stall, mem_err, lock_o, fs_o, ds_o, regwr_o, br_o;
    logic [7:0]  op_o;
    logic [3:0]  dest_o;
    logic [15:0] wb_o, bpc_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cur_vec  = -1;

    mem_stage_if #(.DATA_WIDTH(16)) dmem ();

    mem_stage #(.DATA_WIDTH(16), .OPCODE_WIDTH(8), .MEM_TIMEOUT(8)) dut (
        .I_CLOCK(clk), .I_RESET_N(rst_n), .I_LOCK(lock_i), .I_ALUOut(alu_i),
        .I_Opcode(op_i), .I_DestRegIdx(dest_i), .I_DestValue(dval_i),
        .I_FetchStall(fs_i), .I_DepStall(ds_i), .dmem(dmem),
        .O_MemStall(mem_stall), .O_MemErr(mem_err), .O_LOCK(lock_o),
        .O_FetchStall(fs_o), .O_DepStall(ds_o), .O_Opcode(op_o), .O_DestRegIdx(dest_o),
        .O_WBValue(wb_o), .O_RegWrite(regwr_o), .O_BranchTaken(br_o), .O_BranchPC(bpc_o)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    typedef struct {
        logic        lock;
        logic [7:0]  op;
        logic [15:0] alu;
        logic [3:0]  dest;
        logic        fs;
        logic        ds;
        logic        ack;
        logic        e_rw;
        logic [15:0] e_wb;
        logic        e_br;
        logic [15:0] e_pc;
    } vec_t;

    vec_t vt[20];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL v%0d %s: got %h expected %h", cur_vec, name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic lk, input logic [7:0] op, input logic [15:0] alu,
                         input logic [3:0] dst, input logic [15:0] dv);
        lock_i = lk; op_i = op; alu_i = alu; dest_i = dst; dval_i = dv; fs_i = 1'b0; ds_i = 1'b0;
    endtask

    task automatic bubble();
        drive(1'b0, OP_NOP, 16'h0000, 4'd0, 16'h0000);
    endtask

    initial begin
        rst_n = 1'b0;
        bubble();
        dmem.ack = 1'b0; dmem.rdata = 16'h0000;
        tick(); tick();
        chk("rst_req", 16'(dmem.req), 16'd0);
        chk("rst_regwr", 16'(regwr_o), 16'd0);
        chk("rst_wb", wb_o, 16'h0000);
        chk("rst_err", 16'(mem_err), 16'd0);
        rst_n = 1'b1;

        vt[0]  = '{1, OP_BRZ,   16'h0040, 4'd0, 0, 0, 0, 0, 16'h0000, 1, 16'h0040};
        vt[1]  = '{1, OP_ADDI,  16'hFFFE, 4'd3, 0, 0, 0, 1, 16'hFFFE, 0, 16'h0000};
        vt[2]  = '{1, OP_BRN,   16'h0080, 4'd0, 0, 0, 0, 0, 16'h0000, 1, 16'h0080};
        vt[3]  = '{1, OP_BRZP,  16'h0090, 4'd0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000};
        vt[4]  = '{0, OP_ADD,   16'h0005, 4'd1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000};
        vt[5]  = '{1, OP_ADD,   16'h0005, 4'd1, 0, 1, 0, 0, 16'h0000, 0, 16'h0000};
        vt[6]  = '{1, OP_MOVI,  16'h0000, 4'd5, 0, 0, 0, 1, 16'h0000, 0, 16'h0000};
        vt[7]  = '{1, OP_BRNP,  16'h0100, 4'd0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000};
        vt[8]  = '{1, OP_BRNZ,  16'h0110, 4'd0, 0, 0, 0, 0, 16'h0000, 1, 16'h0110};
        vt[9]  = '{1, OP_AND,   16'h0007, 4'd1, 0, 0, 0, 1, 16'h0007, 0, 16'h0000};
        vt[10] = '{1, OP_BRP,   16'h0120, 4'd0, 0, 0, 0, 0, 16'h0000, 1, 16'h0120};
        vt[11] = '{1, OP_JMP,   16'h0200, 4'd0, 0, 0, 0, 0, 16'h0000, 1, 16'h0200};
        vt[12] = '{1, OP_NOP,   16'h0300, 4'd9, 0, 0, 0, 0, 16'h0000, 0, 16'h0000};
        vt[13] = '{1, OP_BRNZ,  16'h0130, 4'd0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000};
        vt[14] = '{1, OP_JSRR,  16'h0300, 4'd0, 0, 0, 0, 0, 16'h0000, 1, 16'h0300};
        vt[15] = '{1, OP_LDW,   16'h0010, 4'd2, 0, 1, 0, 0, 16'h0000, 0, 16'h0000};
        vt[16] = '{1, OP_MOV,   16'h8000, 4'd4, 1, 0, 0, 0, 16'h0000, 0, 16'h0000};
        vt[17] = '{1, OP_MOV,   16'h8000, 4'd4, 0, 0, 0, 1, 16'h8000, 0, 16'h0000};
        vt[18] = '{1, OP_BRNZP, 16'h0140, 4'd0, 0, 0, 0, 0, 16'h0000, 1, 16'h0140};
        vt[19] = '{1, OP_ADD,   16'hF000, 4'd8, 0, 0, 1, 1, 16'hF000, 0, 16'h0000};

        for (int i = 0; i < 20; i++) begin
            cur_vec = i;
            lock_i = vt[i].lock; op_i = vt[i].op; alu_i = vt[i].alu; dest_i = vt[i].dest;
            dval_i = 16'h0000; fs_i = vt[i].fs; ds_i = vt[i].ds; dmem.ack = vt[i].ack;
            tick();
            chk("regwr", 16'(regwr_o), 16'(vt[i].e_rw));
            chk("br", 16'(br_o), 16'(vt[i].e_br));
            chk("req", 16'(dmem.req), 16'd0);
            chk("lock", 16'(lock_o), 16'(vt[i].lock));
            chk("fstall", 16'(fs_o), 16'(vt[i].fs));
            chk("dstall", 16'(ds_o), 16'(vt[i].ds));
            chk("opcode", 16'(op_o), 16'(vt[i].op));
            chk("dest", 16'(dest_o), 16'(vt[i].dest));
            if (vt[i].e_rw) chk("wb", wb_o, vt[i].e_wb);
            if (vt[i].e_br) chk("bpc", bpc_o, vt[i].e_pc);
        end
        dmem.ack = 1'b0;

        // LDW 0x0010 acked on the third edge; CC was N, so the trailing BRP proves CC=P
        cur_vec = 100;
        drive(1'b1, OP_LDW, 16'h0010, 4'd4, 16'h0000);
        tick();
        chk("ld_req0", 16'(dmem.req), 16'd1);
        chk("ld_stall0", 16'(mem_stall), 16'd1);
        chk("ld_we", 16'(dmem.we), 16'd0);
        chk("ld_addr", dmem.addr, 16'h0010);
        drive(1'b1, OP_BRP, 16'h0050, 4'd0, 16'h0000);
        for (int k = 1; k <= 2; k++) begin
            tick();
            chk("ld_req_wait", 16'(dmem.req), 16'd1);
            chk("ld_stall_wait", 16'(mem_stall), 16'd1);
            chk("ld_addr_hold", dmem.addr, 16'h0010);
            chk("ld_regwr_wait", 16'(regwr_o), 16'd0);
            chk("ld_br_wait", 16'(br_o), 16'd0);
        end
        dmem.ack = 1'b1; dmem.rdata = 16'h1234;
        tick();
        dmem.ack = 1'b0; dmem.rdata = 16'h0000;
        chk("ld_req_done", 16'(dmem.req), 16'd0);
        chk("ld_stall_done", 16'(mem_stall), 16'd0);
        chk("ld_regwr", 16'(regwr_o), 16'd1);
        chk("ld_wb", wb_o, 16'h1234);
        chk("ld_dest", 16'(dest_o), 16'd4);
        tick();
        chk("ld_regwr_pulse", 16'(regwr_o), 16'd0);
        chk("ld_brp_taken", 16'(br_o), 16'd1);
        chk("ld_brp_pc", bpc_o, 16'h0050);
        chk("ld_no_reissue", 16'(dmem.req), 16'd0);
        bubble();
        tick();
        chk("br_pulse", 16'(br_o), 16'd0);

        // STW acked on the first edge
        cur_vec = 101;
        drive(1'b1, OP_STW, 16'h0020, 4'd6, 16'hBEEF);
        tick();
        chk("st_req", 16'(dmem.req), 16'd1);
        chk("st_we", 16'(dmem.we), 16'd1);
        chk("st_addr", dmem.addr, 16'h0020);
        chk("st_wdata", dmem.wdata, 16'hBEEF);
        chk("st_stall", 16'(mem_stall), 16'd1);
        bubble();
        dmem.ack = 1'b1;
        tick();
        dmem.ack = 1'b0;
        chk("st_req_done", 16'(dmem.req), 16'd0);
        chk("st_stall_done", 16'(mem_stall), 16'd0);
        chk("st_regwr", 16'(regwr_o), 16'd0);
        tick();
        chk("st_regwr_after", 16'(regwr_o), 16'd0);

        // Ack on the same edge as the timeout limit completes normally
        cur_vec = 102;
        drive(1'b1, OP_LDW, 16'h0030, 4'd5, 16'h0000);
        tick();
        bubble();
        for (int k = 1; k <= 7; k++) tick();
        chk("lim_req_hold", 16'(dmem.req), 16'd1);
        dmem.ack = 1'b1; dmem.rdata = 16'h0ABC;
        tick();
        dmem.ack = 1'b0;
        chk("lim_req", 16'(dmem.req), 16'd0);
        chk("lim_err", 16'(mem_err), 16'd0);
        chk("lim_regwr", 16'(regwr_o), 16'd1);
        chk("lim_wb", wb_o, 16'h0ABC);

        // Timeout: no ack for MEM_TIMEOUT edges
        cur_vec = 103;
        drive(1'b1, OP_LDW, 16'h0030, 4'd6, 16'h0000);
        tick();
        bubble();
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("to_req_hold", 16'(dmem.req), 16'd1);
            chk("to_err_clear", 16'(mem_err), 16'd0);
        end
        tick();
        chk("to_req", 16'(dmem.req), 16'd0);
        chk("to_stall", 16'(mem_stall), 16'd0);
        chk("to_err", 16'(mem_err), 16'd1);
        chk("to_regwr", 16'(regwr_o), 16'd0);
        drive(1'b1, OP_ADD, 16'h0009, 4'd7, 16'h0000);
        tick();
        chk("to_add_regwr", 16'(regwr_o), 16'd1);
        chk("to_add_wb", wb_o, 16'h0009);
        chk("to_err_sticky", 16'(mem_err), 16'd1);

        // Reset asserted mid-WAIT_RD, between clock edges
        cur_vec = 104;
        drive(1'b1, OP_LDW, 16'h0044, 4'd3, 16'h0000);
        tick();
        tick();
        chk("rw_req", 16'(dmem.req), 16'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_req", 16'(dmem.req), 16'd0);
        chk("ar_stall", 16'(mem_stall), 16'd0);
        chk("ar_err", 16'(mem_err), 16'd0);
        chk("ar_addr", dmem.addr, 16'h0000);
        chk("ar_lock", 16'(lock_o), 16'd0);
        chk("ar_opcode", 16'(op_o), 16'd0);
        chk("ar_dest", 16'(dest_o), 16'd0);
        chk("ar_wb", wb_o, 16'h0000);
        chk("ar_bpc", bpc_o, 16'h0000);
        bubble();
        #1 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ar_no_req", 16'(dmem.req), 16'd0);
            chk("ar_no_regwr", 16'(regwr_o), 16'd0);
        end
        dmem.ack = 1'b1;
        tick();
        dmem.ack = 1'b0;
        chk("idle_ack_ignored", 16'(regwr_o), 16'd0);
        drive(1'b1, OP_BRZ, 16'h0040, 4'd0, 16'h0000);
        tick();
        chk("ar_brz_taken", 16'(br_o), 16'd1);
        chk("ar_brz_pc", bpc_o, 16'h0040);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
